fpu_mac_seq: RTL
================

Name: fpu_mac_seq

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point unit for the neuron datapath. Generalises the fp16 add and multiply blocks to any exponent/mantissa width.
- Ops: add, sub, mul, and multiply-accumulate into an internal accumulator.
- Sequential: shift-per-cycle align/normalise state machine with valid/ready handshakes on input and output. Sits between neuron weight/input fetch and activation logic.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa width (hidden bit excluded).
- W, 1+EXP_W+MAN_W, total word width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit can accept an operation.
- op  in  2  00 add, 01 sub (a-b), 10 mul, 11 mac (acc = acc + a*b).
- a  in  W  operand A.
- b  in  W  operand B.
- acc_clr  in  1  synchronous accumulator clear; acts only when the unit is in IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  result. For mac, this is the new accumulator value.
- ovf  out  1  result overflowed to infinity.
- unf  out  1  result flushed to zero.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=1; out_valid=0; result=0; ovf=0; unf=0; accumulator=0.
  - Reset mid-operation aborts the operation; no output is produced.
- Encoding:
  - Bias = 2^(EXP_W-1)-1.
  - Exponent 0 means zero; subnormal inputs are treated as signed zero.
  - Exponent all-ones on input is treated as infinity: result is infinity with the XOR sign (mul) or the operand's sign (add).
  - NaN is not supported.
- Handshakes:
  - Input transfer occurs on in_valid & in_ready. in_ready=1 only in IDLE.
  - out_valid stays high and result/flags stay stable until out_ready=1, then the unit returns to IDLE on the next edge.
- States:
  - IDLE: on transfer, register the operands and op. Sub inverts b's sign. Go to MUL for mul/mac, otherwise ALIGN. If acc_clr=1 and there is no transfer, accumulator<=0. If acc_clr=1 and a transfer occurs in the same cycle, clear first; the mac then uses acc=0.
  - MUL (1 cycle):
    - Product mantissa = (1.MAN_W) x (1.MAN_W), giving a 2*MAN_W+2-bit product.
    - Exponent = ea+eb-bias, held at EXP_W+2 bits signed.
    - Zero operand: product is signed zero.
    - mul goes to NORM. mac loads the product as operand X with the accumulator as Y, then goes to ALIGN.
  - ALIGN:
    - Mantissas are held with 3 extra LSBs (guard/round/sticky).
    - Each cycle, shift the smaller-exponent mantissa right by 1, OR shifted-out bits into sticky, and increment its exponent.
    - Exit when the exponents are equal or the smaller mantissa is zero; the loop is bounded by MAN_W+4 cycles.
    - A zero operand skips ALIGN immediately.
  - ADD (1 cycle):
    - Equal signs: add magnitudes.
    - Otherwise: subtract the smaller magnitude from the larger; the sign is the larger magnitude's sign.
    - Exact zero difference gives +0.
  - NORM:
    - On carry-out, shift right 1 and increment the exponent (one cycle).
    - Then shift left 1 per cycle, decrementing the exponent, until the hidden bit is set. Bounded by MAN_W+4 cycles.
    - A zero mantissa goes straight to ROUND.
  - ROUND (1 cycle):
    - Default rounding is truncation.
    - Exponent >= 2^EXP_W-1: result is infinity (exp all-ones, mantissa 0), ovf=1.
    - Exponent <= 0: result is signed zero, unf=1.
    - For mac, write the result to the accumulator.
    - Go to DONE.
  - DONE: out_valid=1; wait for out_ready.
- Flags are cleared at the next input transfer.

Optional Feature:
- FPU_RNE_EN: when defined, ROUND applies round-to-nearest-even using guard/round/sticky.
  - A mantissa carry-out renormalises (exponent+1) and may trigger ovf.
- When undefined, the result is truncated and the guard/sticky logic may be removed.

Test Plan:
- add 0x3C00 + 0x4000 (1.0+2.0) -> result 0x4200, ovf=0, unf=0; in_ready low until out handshake completes.
- sub 0x4200 - 0x4200 -> 0x0000; sub 0x3C00 - 0x4000 -> 0xBC00 (-1.0); NORM path exercised.
- mul 0x3E00 x 0x4000 (1.5x2.0) -> 0x4200; mul 0x7BFF x 0x7BFF -> 0x7C00 with ovf=1; mul 0x0400 x 0x3800 -> 0x0000 with unf=1.
- acc_clr, then mac 0x4000,0x3E00 twice -> results 0x4200 then 0x4600 (6.0); acc_clr with simultaneous mac -> 0x4200.
- hold out_ready=0 for 5 cycles after out_valid -> result stable, in_valid ignored; assert rst_n=0 mid-ALIGN -> out_valid=0, in_ready=1, accumulator=0.
- FPU_RNE_EN defined: add 0x3C00 + 0x1001 -> 0x3C01 (round up); undefined -> 0x3C00.

Source files
------------

// File: rtl/fpu_mac_seq_if.sv
// -----------------------------------------------------------------------------
// fpu_mac_seq_if
// Handshake/data bundle between a requester and the fpu_mac_seq unit.
//
// Valid/ready contract (both channels): a beat transfers on the rising clock
// edge where valid and ready are both high. The producer holds valid and its
// payload stable until that edge; ready may change freely.
//
// Signals (W = 1 + EXP_W + MAN_W):
//   in_valid  / in_ready   : operation request channel
//   op[1:0]                : 00 add, 01 sub (a-b), 10 mul, 11 mac
//   a, b      [W-1:0]      : operands
//   acc_clr                : clear accumulator (honoured only while idle)
//   out_valid / out_ready  : result channel
//   result    [W-1:0]      : result word (new accumulator for mac)
//   ovf, unf               : overflow-to-infinity / flush-to-zero flags
// Modports: master = requester side, slave = fpu_mac_seq side.
// -----------------------------------------------------------------------------
interface fpu_mac_seq_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         unf;

    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, result, ovf, unf
    );

    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, result, ovf, unf
    );
endinterface

// File: rtl/fpu_mac_seq.sv
// -----------------------------------------------------------------------------
// fpu_mac_seq
// Multi-cycle floating-point add/sub/mul/multiply-accumulate unit with a
// parametrised exponent/mantissa format. Alignment and normalisation shift one
// bit per cycle. Subnormals read as signed zero, exponent all-ones reads as
// infinity, NaN is not supported.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : fpu_mac_seq_if.slave (request/result channels, flags)
//   state_dbg_o : current FSM state (IDLE=0 MUL=1 ALIGN=2 ADD=3 NORM=4
//                 ROUND=5 DONE=6)
//
// Build option: define FPU_RNE_EN for round-to-nearest-even; otherwise the
// result is truncated.
//
// Internal mantissa layout (MX = MAN_W+5 bits):
//   [MX-1] carry, [MX-2] hidden one, [MX-3:3] fraction, [2:0] guard/round/sticky
// -----------------------------------------------------------------------------
module fpu_mac_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    fpu_mac_seq_if.slave bus,
    output logic [2:0] state_dbg_o
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;          // signed working exponent
    localparam int MX   = MAN_W + 5;          // working mantissa
    localparam int PW   = 2 * MAN_W + 2;      // raw product width
    localparam int CW   = $clog2(MAN_W + 5) + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);
    localparam logic signed [EW-1:0] ZERO_E = '0;
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic [CW-1:0]        LIM    = CW'(MAN_W + 4);

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_ROUND = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic                  xs_q, xs_d, ys_q, ys_d;
    logic signed [EW-1:0]  xe_q, xe_d, ye_q, ye_d;
    logic [MX-1:0]         xm_q, xm_d, ym_q, ym_d;
    logic                  inf_q, inf_d, inf_s_q, inf_s_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W-1:0]          acc_q, acc_d;
    logic [W-1:0]          result_q, result_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    function automatic logic [MX-1:0] unpack_man(input logic [W-1:0] v);
        if (v[W-2:MAN_W] == '0) return '0;
        return {2'b01, v[MAN_W-1:0], 3'b000};
    endfunction

    function automatic logic signed [EW-1:0] unpack_exp(input logic [W-1:0] v);
        return {2'b00, v[W-2:MAN_W]};
    endfunction

    function automatic logic is_inf(input logic [W-1:0] v);
        return &v[W-2:MAN_W];
    endfunction

    // Right shift by one; anything falling off is folded into the sticky bit.
    function automatic logic [MX-1:0] shr1(input logic [MX-1:0] m);
        return {1'b0, m[MX-1:2], m[1] | m[0]};
    endfunction

    // ---------------- shared combinational datapath -------------------------
    logic [W-1:0]         b_eff;
    logic [PW-1:0]        prod;
    logic [PW+2:0]        prod_ext;
    logic [MX-1:0]        prod_m, prod_nm;
    logic signed [EW-1:0] prod_e, prod_ne;
    logic                 prod_zero;
    logic                 align_done, norm_done;
    logic                 x_ge;
    logic [MX-1:0]        add_m;
    logic                 add_s;
    logic signed [EW-1:0] add_e;
    logic [MAN_W-1:0]     rnd_frac;
    logic signed [EW-1:0] rnd_e;
    logic [W-1:0]         rnd_word;
    logic                 rnd_ovf, rnd_unf;

    assign b_eff = (bus.op == OP_SUB) ? {~bus.b[W-1], bus.b[W-2:0]} : bus.b;

    assign prod      = PW'(xm_q[MX-2:3]) * PW'(ym_q[MX-2:3]);
    assign prod_ext  = {prod, 3'b000};
    assign prod_m    = {prod_ext[PW+2:MAN_W+1], prod_ext[MAN_W] | (|prod_ext[MAN_W-1:0])};
    assign prod_e    = xe_q + ye_q - BIAS_E;
    assign prod_zero = (xm_q == '0) || (ym_q == '0);
    // The mac product is pre-normalised so the following add cannot overflow
    // the carry bit.
    assign prod_nm   = prod_m[MX-1] ? shr1(prod_m) : prod_m;
    assign prod_ne   = prod_m[MX-1] ? prod_e + ONE_E : prod_e;

    assign align_done = (xm_q == '0) || (ym_q == '0) || (xe_q == ye_q) || (cnt_q == LIM);
    assign norm_done  = (xm_q == '0) || (!xm_q[MX-1] && (xm_q[MX-2] || cnt_q == LIM));

    assign x_ge  = (xm_q >= ym_q);
    assign add_m = (xs_q == ys_q) ? xm_q + ym_q : (x_ge ? xm_q - ym_q : ym_q - xm_q);
    always_comb begin
        add_s = (xs_q == ys_q) ? xs_q : (x_ge ? xs_q : ys_q);
        if (xs_q != ys_q && add_m == '0) add_s = 1'b0;
        // A zero operand carries no meaningful exponent.
        if (xm_q == '0)       add_e = ye_q;
        else if (ym_q == '0)  add_e = xe_q;
        else                  add_e = (xe_q > ye_q) ? xe_q : ye_q;
    end

`ifdef FPU_RNE_EN
    logic               rnd_up;
    logic [MAN_W+1:0]   rnd_sum;
    assign rnd_up   = xm_q[2] & (xm_q[1] | xm_q[0] | xm_q[3]);
    assign rnd_sum  = {1'b0, xm_q[MX-2:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    // Carry out of 1.11..1 + ulp gives 10.00..0: fraction clears, exponent +1.
    assign rnd_frac = rnd_sum[MAN_W+1] ? '0 : rnd_sum[MAN_W-1:0];
    assign rnd_e    = rnd_sum[MAN_W+1] ? xe_q + ONE_E : xe_q;
`else
    assign rnd_frac = xm_q[MX-3:3];
    assign rnd_e    = xe_q;
`endif

    always_comb begin
        rnd_word = {xs_q, rnd_e[EXP_W-1:0], rnd_frac};
        rnd_ovf  = 1'b0;
        rnd_unf  = 1'b0;
        if (inf_q) begin
            rnd_word = {inf_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (xm_q == '0) begin
            rnd_word = {xs_q, {(W-1){1'b0}}};
        end else if (rnd_e >= EMAX_E) begin
            rnd_word = {xs_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_ovf  = 1'b1;
        end else if (rnd_e <= ZERO_E) begin
            rnd_word = {xs_q, {(W-1){1'b0}}};
            rnd_unf  = 1'b1;
        end
    end

    // ---------------- FSM: state register -----------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ---------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = bus.op[1] ? S_MUL : S_ALIGN;
            S_MUL: begin
                if (inf_q || (op_q == OP_MAC && is_inf(acc_q))) state_d = S_ROUND;
                else if (op_q == OP_MUL)                        state_d = S_NORM;
                else                                            state_d = S_ALIGN;
            end
            S_ALIGN: begin
                if (inf_q)           state_d = S_ROUND;
                else if (align_done) state_d = S_ADD;
            end
            S_ADD:   state_d = S_NORM;
            S_NORM:  if (norm_done) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ------------------------------------------
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.result    = result_q;
        bus.ovf       = ovf_q;
        bus.unf       = unf_q;
        state_dbg_o   = state_q;
    end

    // ---------------- datapath next-state -----------------------------------
    always_comb begin
        op_d     = op_q;
        xs_d     = xs_q;
        xe_d     = xe_q;
        xm_d     = xm_q;
        ys_d     = ys_q;
        ye_d     = ye_q;
        ym_d     = ym_q;
        inf_d    = inf_q;
        inf_s_d  = inf_s_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        case (state_q)
            S_IDLE: begin
                // Clear takes effect before a simultaneous mac reads the acc.
                if (bus.acc_clr) acc_d = '0;
                if (bus.in_valid) begin
                    op_d  = bus.op;
                    xs_d  = bus.a[W-1];
                    xe_d  = unpack_exp(bus.a);
                    xm_d  = unpack_man(bus.a);
                    ys_d  = b_eff[W-1];
                    ye_d  = unpack_exp(b_eff);
                    ym_d  = unpack_man(b_eff);
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    inf_d = is_inf(bus.a) || is_inf(b_eff);
                    if (bus.op[1]) inf_s_d = bus.a[W-1] ^ bus.b[W-1];
                    else           inf_s_d = is_inf(bus.a) ? bus.a[W-1] : b_eff[W-1];
                end
            end
            S_MUL: begin
                xs_d  = xs_q ^ ys_q;
                cnt_d = '0;
                if (prod_zero) begin
                    xm_d = '0;
                    xe_d = ZERO_E;
                end else if (op_q == OP_MUL) begin
                    xm_d = prod_m;
                    xe_d = prod_e;
                end else begin
                    xm_d = prod_nm;
                    xe_d = prod_ne;
                end
                if (op_q == OP_MAC) begin
                    ys_d = acc_q[W-1];
                    ye_d = unpack_exp(acc_q);
                    ym_d = unpack_man(acc_q);
                    if (!inf_q && is_inf(acc_q)) begin
                        inf_d   = 1'b1;
                        inf_s_d = acc_q[W-1];
                    end
                end
            end
            S_ALIGN: begin
                if (!align_done) begin
                    cnt_d = cnt_q + CW'(1);
                    if (xe_q < ye_q) begin
                        xm_d = shr1(xm_q);
                        xe_d = xe_q + ONE_E;
                    end else begin
                        ym_d = shr1(ym_q);
                        ye_d = ye_q + ONE_E;
                    end
                end
            end
            S_ADD: begin
                xm_d  = add_m;
                xs_d  = add_s;
                xe_d  = add_e;
                cnt_d = '0;
            end
            S_NORM: begin
                if (!norm_done) begin
                    if (xm_q[MX-1]) begin
                        xm_d = shr1(xm_q);
                        xe_d = xe_q + ONE_E;
                    end else begin
                        xm_d  = {xm_q[MX-2:0], 1'b0};
                        xe_d  = xe_q - ONE_E;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_ROUND: begin
                result_d = rnd_word;
                ovf_d    = rnd_ovf;
                unf_d    = rnd_unf;
                if (op_q == OP_MAC) acc_d = rnd_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            xs_q     <= 1'b0;
            xe_q     <= '0;
            xm_q     <= '0;
            ys_q     <= 1'b0;
            ye_q     <= '0;
            ym_q     <= '0;
            inf_q    <= 1'b0;
            inf_s_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            xs_q     <= xs_d;
            xe_q     <= xe_d;
            xm_q     <= xm_d;
            ys_q     <= ys_d;
            ye_q     <= ye_d;
            ym_q     <= ym_d;
            inf_q    <= inf_d;
            inf_s_q  <= inf_s_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule
